ifu_idu_buffer: RTL and testbench
=================================

Name: ifu_idu_buffer

Overview:
- Decoupling buffer between the instruction fetch unit and the decode unit in the NPC core.
- Accepts (pc, inst) pairs from fetch through a valid/ready handshake and presents them to decode in order.
- Pre-decodes control-flow, illegal and ebreak flags on the head entry.
- Discards all buffered entries on flush (taken jump/branch redirect) and counts discarded instructions.

Parameters:
- MEM_ADDR_WIDTH, 32, width of pc
- DATA_WIDTH, 32, width of instruction word
- DEPTH, 2, number of entries; must be a power of two, >= 2
- CNT_WIDTH, 32, width of the saturating flush-drop counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents a valid (pc, inst)
- in_ready  out  1  buffer can accept an entry this cycle
- in_pc  in  MEM_ADDR_WIDTH  pc of fetched instruction
- in_inst  in  DATA_WIDTH  fetched instruction word
- flush  in  1  redirect; discard all buffered entries
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  MEM_ADDR_WIDTH  pc of head entry
- out_inst  out  DATA_WIDTH  instruction of head entry
- out_is_ctrl  out  1  head opcode is JAL (1101111), JALR (1100111) or BRANCH (1100011)
- out_is_ebreak  out  1  head inst == 32'h00100073
- out_illegal  out  1  head inst[1:0] != 2'b11
- occupancy  out  $clog2(DEPTH)+1  number of valid entries
- drop_cnt  out  CNT_WIDTH  saturating count of entries discarded by flush

Behaviour:
- Reset (rst=1 at clock edge): pointers, occupancy, drop_cnt and all storage cleared to 0. out_valid=0. in_ready=1 from the first cycle after reset.
- Storage: circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap naturally. Occupancy counter is one bit wider.
- in_ready = (occupancy < DEPTH); registered-state only, no combinational path from out_ready.
- out_valid = (occupancy != 0).
- Push when in_valid & in_ready & !flush. Pop when out_valid & out_ready & !flush.
- Latency: no bypass. An entry pushed at edge N is visible on out_* in the cycle after edge N (minimum 1 cycle).
- Simultaneous push and pop (not full, not empty): occupancy unchanged, both pointers advance.
- Full: in_ready=0; a push is not accepted even if a pop occurs in the same cycle.
- Empty: out_valid=0; out_pc=0, out_inst=0 and all pre-decode flags=0 (deterministic, never stale data).
- Flush has priority over push and pop. At the next edge:
  - occupancy and pointers go to 0; the in_* pair offered that cycle is discarded.
  - drop_cnt += occupancy (pre-flush value); drop_cnt saturates at all-ones.
- Flush while empty: no state change; drop_cnt unchanged.
- Pre-decode is combinational on the head entry only; it does not alter stored data.
- in_pc/in_inst are captured only on an accepted push; held values while in_valid=0 are ignored.
- Reset asserted mid-operation overrides flush, push and pop.

Decomposition:
- Shared defines/package entries:
  - opcode constants OPC_JAL, OPC_JALR, OPC_BRANCH
  - INST_EBREAK = 32'h00100073
  - INST_NOP = 32'h00000013
  - MBASE (reset pc, 32'h80000000)
  - ILEN_MASK check constant 2'b11
- One sub-module: inst_predecode, purely combinational: inst -> is_ctrl, is_ebreak, illegal. The decode unit reuses it later.

Test Plan:
- Reset then single push (pc=32'h80000000, inst=32'h00000013), out_ready=1 -> out_valid=1 exactly one cycle later with matching pc/inst and all flags 0; occupancy returns to 0 after the pop.
- Push 3 back-to-back (pcs 80000000/80000004/80000008), out_ready=0 -> in_ready=0 after two accepts, third held by fetch. Raise out_ready -> order preserved 80000000, 80000004, 80000008, and pointer wrap is correct.
- Full buffer, then flush=1 with in_valid=1 (pc=8000000c) -> next cycle occupancy=0, out_valid=0, drop_cnt=2, 8000000c not stored.
- Head inst=32'h0000006f (JAL) -> out_is_ctrl=1. inst=32'h00100073 -> out_is_ebreak=1. inst=32'h00000000 -> out_illegal=1.
- Steady streaming with in_valid=out_ready=1 for 100 cycles, pc stepping by 4 -> one instruction per cycle after the first, occupancy stays 1, no drops.
- Force drop_cnt to 32'hFFFFFFFF, then flush with occupancy=2 -> drop_cnt stays 32'hFFFFFFFF. Assert rst during streaming -> all outputs zero the next cycle.

Source files
------------

// File: rtl/ifu_idu_buffer_pkg.sv
// Shared constants for the fetch/decode boundary: RV32 opcodes, special
// instruction encodings and the reset PC.
package ifu_idu_buffer_pkg;

  localparam logic [6:0]  OPC_JAL     = 7'b1101111;
  localparam logic [6:0]  OPC_JALR    = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] MBASE       = 32'h8000_0000;

  localparam logic [1:0]  ILEN_MASK   = 2'b11;

endpackage

// File: rtl/ifu_idu_buffer_predecode.sv
// Combinational pre-decode of one instruction word: control-flow, ebreak and
// illegal-length flags. Stateless so the decode unit can reuse it as is.
module inst_predecode
  import ifu_idu_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] inst,
  output logic                  is_ctrl,
  output logic                  is_ebreak,
  output logic                  illegal
);

  logic [6:0] opcode;

  assign opcode    = inst[6:0];
  assign is_ctrl   = (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
  assign is_ebreak = (inst == DATA_WIDTH'(INST_EBREAK));
  // Compressed encodings are not supported, so anything without 2'b11 is illegal.
  assign illegal   = (inst[1:0] != ILEN_MASK);

endmodule

// File: rtl/ifu_idu_buffer.sv
// Fetch-to-decode decoupling FIFO with head-entry pre-decode, flush on
// redirect and a saturating count of instructions discarded by flushes.
module ifu_idu_buffer
  import ifu_idu_buffer_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]  in_pc,
  input  logic [DATA_WIDTH-1:0]      in_inst,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MEM_ADDR_WIDTH-1:0]  out_pc,
  output logic [DATA_WIDTH-1:0]      out_inst,
  output logic                       out_is_ctrl,
  output logic                       out_is_ebreak,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_WIDTH-1:0]       drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = CNT_WIDTH + 1;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]     inst;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [OCC_W-1:0]     occ_q,  occ_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [SUM_W-1:0]     drop_sum;
  logic                 push, pop;
  logic                 pd_ctrl, pd_ebreak, pd_illegal;

  assign in_ready  = (occ_q < OCC_W'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign drop_sum  = {1'b0, drop_q} + SUM_W'(occ_q);

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    drop_d = drop_q;
    if (flush) begin
      if (occ_q != '0) begin
        head_d = '0;
        tail_d = '0;
        occ_d  = '0;
        drop_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
      end
    end else begin
      if (push) begin
        mem_d[tail_q] = '{pc: in_pc, inst: in_inst};
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      drop_q <= '0;
      // NOTE: storage is cleared too, so nothing stale is ever observable after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
      mem_q  <= mem_d;
    end
  end

  assign out_pc    = out_valid ? mem_q[head_q].pc   : '0;
  assign out_inst  = out_valid ? mem_q[head_q].inst : '0;
  assign occupancy = occ_q;
  assign drop_cnt  = drop_q;

  inst_predecode #(.DATA_WIDTH(DATA_WIDTH)) u_predecode (
    .inst      (out_inst),
    .is_ctrl   (pd_ctrl),
    .is_ebreak (pd_ebreak),
    .illegal   (pd_illegal)
  );

  // An empty head reads as all-zero, which would otherwise decode as illegal.
  assign out_is_ctrl   = out_valid & pd_ctrl;
  assign out_is_ebreak = out_valid & pd_ebreak;
  assign out_illegal   = out_valid & pd_illegal;

endmodule

// File: tb/tb_ifu_idu_buffer.sv
// Scoreboard bench for ifu_idu_buffer: accepted pushes queue expected entries,
// a negedge monitor pops and compares on every decode handshake.
module tb_ifu_idu_buffer;
  import ifu_idu_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush, out_ready;
  logic [31:0]   in_pc, in_inst;
  logic          in_ready, out_valid, out_is_ctrl, out_is_ebreak, out_illegal;
  logic [31:0]   out_pc, out_inst, drop_cnt;
  logic [OW-1:0] occupancy;

  logic          s_in_ready, s_out_valid, s_ctrl, s_ebreak, s_illegal;
  logic [31:0]   s_out_pc, s_out_inst;
  logic [OW-1:0] s_occupancy;
  logic [1:0]    s_drop_cnt;

  always #5 clk = ~clk;

  ifu_idu_buffer #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_is_ctrl(out_is_ctrl),
    .out_is_ebreak(out_is_ebreak), .out_illegal(out_illegal), .occupancy(occupancy),
    .drop_cnt(drop_cnt)
  );

  // Narrow counter copy sharing the same stimulus, to reach saturation quickly.
  ifu_idu_buffer #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_inst(s_out_inst), .out_is_ctrl(s_ctrl),
    .out_is_ebreak(s_ebreak), .out_illegal(s_illegal), .occupancy(s_occupancy),
    .drop_cnt(s_drop_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pre-decode: {is_ctrl, is_ebreak, illegal}.
  function automatic logic [2:0] model_flags(input logic [31:0] inst);
    logic c;
    c = (inst[6:0] == 7'b1101111) || (inst[6:0] == 7'b1100111) || (inst[6:0] == 7'b1100011);
    return {c, inst == 32'h0010_0073, inst[1:0] != 2'b11};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %h, expected no entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", 64'(out_pc), 64'(e.pc));
          check("pop_inst", 64'(out_inst), 64'(e.inst));
          check("pop_flags", 64'({out_is_ctrl, out_is_ebreak, out_illegal}), 64'(model_flags(e.inst)));
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{in_pc, in_inst});
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_out_inst"}, 64'(out_inst), 64'd0);
    check({tag, "_flags"}, 64'({out_is_ctrl, out_is_ebreak, out_illegal}), 64'd0);
  endtask

  logic [31:0] pd_inst  [6] = '{32'h0000_006f, 32'h0010_0073, 32'h0000_0000,
                                32'h0000_0063, 32'h0000_0067, 32'h0000_0001};
  logic [2:0]  pd_flags [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b100, 3'b001};

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_idle("reset");
    check("reset_drop", 64'(drop_cnt), 64'd0);
    check("reset_drop_sat", 64'(s_drop_cnt), 64'd0);
    step();

    // Single push, one-cycle latency, pop
    drive(1'b1, MBASE, INST_NOP, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_no_bypass", 64'(out_valid), 64'd0);
    step();
    drive(1'b0, 32'hdead_beef, 32'hdead_beef, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_occ", 64'(occupancy), 64'd1);
    check("t1_pc", 64'(out_pc), 64'(MBASE));
    step();
    @(negedge clk);
    check("t1_occ_after", 64'(occupancy), 64'd0);
    step();

    // Fill to full, backpressure, ordered drain with pointer wrap
    drive(1'b1, 32'h8000_0000, INST_NOP, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8000_0004, INST_NOP, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_ready_1", 64'(in_ready), 64'd1);
    step();
    drive(1'b1, 32'h8000_0008, INST_NOP, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_full_ready", 64'(in_ready), 64'd0);
    check("t2_full_occ", 64'(occupancy), 64'd2);
    step();
    drive(1'b1, 32'h8000_0008, INST_NOP, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_full_pop_ready", 64'(in_ready), 64'd0);
    check("t2_head0", 64'(out_pc), 64'h8000_0000);
    step();
    @(negedge clk);
    check("t2_occ_after_pop", 64'(occupancy), 64'd1);
    check("t2_head1", 64'(out_pc), 64'h8000_0004);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_occ_pushpop", 64'(occupancy), 64'd1);
    check("t2_head2", 64'(out_pc), 64'h8000_0008);
    step();
    @(negedge clk);
    check("t2_drained", 64'(out_valid), 64'd0);
    step();

    // Flush on full buffer with a fetch offered the same cycle
    drive(1'b1, 32'h8000_0000, INST_NOP, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8000_0004, INST_NOP, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h8000_000c, INST_NOP, 1'b1, 1'b1);
    @(negedge clk);
    check("t3_pre_occ", 64'(occupancy), 64'd2);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("t3_flushed");
    check("t3_drop", 64'(drop_cnt), 64'd2);
    check("t3_drop_sat", 64'(s_drop_cnt), 64'd2);
    step();
    @(negedge clk);
    check("t3_not_stored", 64'(out_valid), 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_empty_flush_drop", 64'(drop_cnt), 64'd2);
    check("t3_empty_flush_occ", 64'(occupancy), 64'd0);
    step();

    // Pre-decode flags on the head entry
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, MBASE + 32'(4 * i), pd_inst[i], 1'b0, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("t4_flags_%0d", i), 64'({out_is_ctrl, out_is_ebreak, out_illegal}),
            64'(pd_flags[i]));
      step();
    end

    // Streaming: one instruction per cycle, occupancy pinned at 1
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, MBASE + 32'(4 * i), INST_NOP | 32'(i << 7), 1'b1, 1'b0);
      @(negedge clk);
      if (i > 0) begin
        check("t5_occ", 64'(occupancy), 64'd1);
        check("t5_pc", 64'(out_pc), 64'(MBASE + 32'(4 * (i - 1))));
      end
      step();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    @(negedge clk);
    check("t5_drained", 64'(occupancy), 64'd0);
    check("t5_no_drops", 64'(drop_cnt), 64'd2);
    step();

    // Counter saturation: narrow copy goes 2 -> 3 -> 3
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h8000_0100, INST_NOP, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h8000_0104, INST_NOP, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("t6_drop_%0d", k), 64'(drop_cnt), 64'(4 + 2 * k));
      check($sformatf("t6_drop_sat_%0d", k), 64'(s_drop_cnt), 64'd3);
      step();
    end

    // Reset mid-stream overrides push, pop and flush
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8000_0200 + 32'(4 * i), INST_NOP, 1'b1, 1'b0);
      step();
    end
    @(negedge clk);
    check("t7_pre_occ", 64'(occupancy), 64'd1);
    step();
    rst = 1'b1;
    drive(1'b1, 32'h8000_0300, INST_NOP, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("t7_reset");
    check("t7_drop", 64'(drop_cnt), 64'd0);
    check("t7_drop_sat", 64'(s_drop_cnt), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
